// File: rtl/bf16_to_int16_conv.sv
// Unpacks a 4-lane BF16 word into four signed 16-bit fixed-point integers, one lane per cycle.
// Optional build macro BF16_CONV_RNE_EN selects round-to-nearest-even instead of truncation.
module bf16_to_int16_conv #(
   parameter int unsigned LANES  = 4,
   parameter int unsigned FRAC_W = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*16-1:0]      in_data,
   input  logic [FRAC_W-1:0]        frac_bits,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*16-1:0]      out_data,
   output logic [LANES-1:0]         out_sat,
   output logic                     busy
);

   localparam int unsigned LANE_W = 16;
   localparam int unsigned DATA_W = LANES * LANE_W;
   localparam int unsigned K_W    = 11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state;
   logic [1:0]            lane_cnt;
   logic [DATA_W-1:0]     data_q;
   logic [FRAC_W-1:0]     frac_q;

   logic [LANE_W-1:0]     lane_bits;
   logic                  sgn;
   logic [7:0]            ex;
   logic [6:0]            mant;
   logic [7:0]            sig;
   logic signed [K_W-1:0] k;
   logic [3:0]            rsh;
   logic [2:0]            lsh;
   logic [15:0]           int_part;
   logic                  round_up;
   logic [16:0]           mag;
   logic [LANE_W-1:0]     lane_res;
   logic                  lane_sat;
`ifdef BF16_CONV_RNE_EN
   logic [15:0]           shifted;
`endif

   // Per-lane BF16 -> int16 conversion for the lane currently selected by lane_cnt
   always_comb begin
      lane_bits = data_q[{lane_cnt, 4'b0000} +: LANE_W];
      sgn       = lane_bits[15];
      ex        = lane_bits[14:7];
      mant      = lane_bits[6:0];
      sig       = {1'b1, mant};
      k         = $signed(K_W'({3'b000, ex}) + K_W'(frac_q)) - 11'sd127;
      rsh       = 4'd0;
      lsh       = 3'd0;
      int_part  = 16'd0;
      round_up  = 1'b0;
      lane_res  = 16'd0;
      lane_sat  = 1'b0;
`ifdef BF16_CONV_RNE_EN
      shifted   = 16'd0;
`endif

      // Magnitude below 2^15: right shift keeps guard/sticky bits, left shift is exact
      if (k >= -11'sd1 && k <= 11'sd6) begin
         rsh = 4'(11'sd7 - k);
`ifdef BF16_CONV_RNE_EN
         shifted  = {sig, 8'h00} >> rsh;
         int_part = {8'h00, shifted[15:8]};
         round_up = shifted[7] & ((|shifted[6:0]) | shifted[8]);
`else
         int_part = {8'h00, sig >> rsh};
`endif
      end else if (k >= 11'sd7 && k <= 11'sd14) begin
         lsh      = 3'(k - 11'sd7);
         int_part = {8'h00, sig} << lsh;
      end

      mag = {1'b0, int_part} + 17'(round_up);

      if (ex == 8'h00) begin
         lane_res = 16'h0000;
         lane_sat = 1'b0;
      end else if (ex == 8'hFF) begin
         lane_sat = 1'b1;
         if (mant != 7'd0) begin
            lane_res = 16'h0000;
         end else begin
            lane_res = sgn ? 16'h8000 : 16'h7FFF;
         end
      end else if (k >= 11'sd15) begin
         // Exactly -32768 is representable, everything else clamps with a flag
         if (sgn) begin
            lane_res = 16'h8000;
            lane_sat = !(k == 11'sd15 && mant == 7'd0);
         end else begin
            lane_res = 16'h7FFF;
            lane_sat = 1'b1;
         end
      end else if (mag >= 17'd32768) begin
         if (sgn) begin
            lane_res = 16'h8000;
            lane_sat = (mag != 17'd32768);
         end else begin
            lane_res = 16'h7FFF;
            lane_sat = 1'b1;
         end
      end else begin
         lane_res = sgn ? (16'd0 - mag[15:0]) : mag[15:0];
         lane_sat = 1'b0;
      end
   end

   // Handshake FSM: accept in IDLE, one lane per edge in CONV, hold result in DONE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         lane_cnt  <= 2'd0;
         data_q    <= '0;
         frac_q    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= '0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  data_q   <= in_data;
                  frac_q   <= frac_bits;
                  out_sat  <= '0;
                  lane_cnt <= 2'd0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= CONV;
               end
            end
            CONV: begin
               out_data[{lane_cnt, 4'b0000} +: LANE_W] <= lane_res;
               out_sat[lane_cnt]                       <= lane_sat;
               lane_cnt                                <= lane_cnt + 2'd1;
               if (lane_cnt == 2'd3) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
